// File: rtl/serial_diff_of_2numbers.sv
`default_nettype none
// ============================================================================
// Module   : serial_diff_of_2numbers
// Brief    : Bit-serial subtractor computing a - b, one bit per clock, LSB
//            first, with borrow/zero/signed-overflow flags.
//            Optional macro SERIAL_DIFF_ABS_EN: reports |a - b| in diff by
//            adding one NEG cycle whenever a < b.
// Revision : 1.0 - initial release
// ============================================================================
module serial_diff_of_2numbers #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);

`ifdef SERIAL_DIFF_ABS_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_NEG  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_finish;

    // One full-subtractor slice; the difference bit enters at the MSB so the
    // result is LSB-aligned after WIDTH shifts.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign w_last     = (r_state == S_RUN) && (r_cnt == c_last_cnt);

`ifdef SERIAL_DIFF_ABS_EN
    logic [WIDTH-1:0] w_neg;
    assign w_neg    = -r_res;
    assign w_finish = w_last && !w_br_next;
`else
    assign w_finish = w_last;
`endif

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
`ifdef SERIAL_DIFF_ABS_EN
                    w_state_next = w_br_next ? S_NEG : S_IDLE;
`else
                    w_state_next = S_IDLE;
`endif
                end
            end
`ifdef SERIAL_DIFF_ABS_EN
            S_NEG:   w_state_next = S_IDLE;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_a     <= a;
                r_b     <= b;
                r_res   <= '0;
                r_br    <= 1'b0;
                r_cnt   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == S_RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_next;
                r_br  <= w_br_next;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                diff   <= w_res_next;
                borrow <= w_br_next;
                zero   <= (w_res_next == '0);
                ovf    <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                done   <= 1'b1;
            end
`ifdef SERIAL_DIFF_ABS_EN
            // Flags are taken from the raw result latched on the last RUN edge.
            if (r_state == S_NEG) begin
                diff   <= w_neg;
                borrow <= r_br;
                zero   <= (w_neg == '0);
                ovf    <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
                done   <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_diff_of_2numbers.md
Name: serial_diff_of_2numbers

Overview:
Bit-serial subtractor. Computes a - b on two WIDTH-bit operands, one bit per clock, LSB first.
- Launched by a single-cycle start pulse; completion reported by a one-cycle done pulse.
- Result and flags are held registered until the next completion.
- It is the subtraction counterpart of the team's combinational sum function. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; a and b are sampled on the same edge
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when diff and the flags are updated
diff  output  WIDTH  result, a - b modulo 2^WIDTH
borrow  output  1  1 when a < b, unsigned compare
zero  output  1  1 when diff == 0
ovf  output  1  signed (two's complement) overflow of a - b

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, ovf=0, bit counter=0, internal shift registers=0.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced for it.
- FSM states: IDLE, RUN, plus NEG when SERIAL_DIFF_ABS_EN is defined.
- IDLE:
  - start=1 latches a and b into shift registers, clears the running borrow and counter, latches a[WIDTH-1] and b[WIDTH-1] for the ovf calculation, and moves to RUN.
  - busy goes high on that same edge.
  - start=0 keeps the FSM in IDLE.
- RUN, each edge:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d is shifted into the MSB of the result register; both operand registers shift right.
  - counter increments.
- Edge at which counter reaches WIDTH (the WIDTH-th RUN edge):
  - diff <= full result; borrow <= final br; zero <= (result == 0).
  - ovf <= (a_msb != b_msb) && (result_msb != a_msb).
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: start sampled at edge 0, done high during the cycle following edge WIDTH (edge 8 for the default).
- start while busy=1 is ignored. Operands are not resampled and the running operation is unaffected.
- start while done=1 is accepted, since the FSM is already in IDLE. This allows back-to-back operations with no gap cycle.
- diff and all flags hold their last values between completions. Before the first completion they read 0.
- Operand changes after the start edge have no effect on the result.

Optional Feature:
Macro: SERIAL_DIFF_ABS_EN
- Defined:
  - When the final borrow = 1, the FSM moves RUN -> NEG instead of completing.
  - NEG lasts one cycle: diff <= two's complement of the result, i.e. |a - b|; zero is recomputed on that value; done pulses; state <= IDLE.
  - Latency is WIDTH+1 when borrow=1 and WIDTH otherwise.
  - borrow still reports a < b. ovf is computed on the raw, pre-negation result.
- Not defined: NEG state does not exist; diff is the raw modulo-2^WIDTH result; latency is always WIDTH.

Test Plan:
1. a=9, b=5, start pulse -> done exactly 8 cycles later; diff=4, borrow=0, zero=0, ovf=0.
2. a=5, b=9 -> diff=252 (0xFC), borrow=1, ovf=0. With SERIAL_DIFF_ABS_EN: diff=4 after 9 cycles, borrow=1.
3. a=7, b=7 -> diff=0, zero=1, borrow=0. Then a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0.
4. Start with a=10, b=2; pulse start again at cycle 3 with a=1, b=1 -> second start ignored; single done with diff=8; busy stays high throughout.
5. Start with a=200, b=100; assert rst at cycle 4 -> all outputs 0 immediately; no done pulse; next start (a=3, b=1) -> diff=2.
6. Back-to-back: assert start in the done cycle of a=20, b=5 (diff=15) with a=1, b=2 -> second done exactly 8 cycles later; diff=255, borrow=1; first result held until then.
